// File: rtl/data_ram_arbiter_pkg.sv
// data_ram_arbiter_pkg: state codes and bus constants shared by the data RAM arbiter.
package data_ram_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;
  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic ID_M0         = 1'b0;
  localparam logic ID_M1         = 1'b1;
endpackage

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way one-hot grant, round-robin against the last winner or fixed M0 priority.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~rr_en | last);
    gnt[1] = req[1] & ~gnt[0];
  end
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the MEM stage (M0) and a debug/DMA port (M1).
module data_ram_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_sel,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_sel,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_sel,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          stallreq_o
);
  import data_ram_arbiter_pkg::*;
  arb_state_t    state_q, state_d;
  logic          id_q, id_d, we_q, we_d, rr_last_q, rr_last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [DW-1:0] wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [1:0]    gnt;
  logic          access, resp;

  rr_arbiter2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (rr_last_q),
    .rr_en (RR_EN),
    .gnt   (gnt)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rr_last_d  = rr_last_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (state_q == ARB_IDLE) begin
      if (|gnt) begin
        state_d = ARB_ACCESS;
        id_d    = gnt[1];
        we_d    = gnt[1] ? m1_we : m0_we;
        addr_d  = gnt[1] ? m1_addr : m0_addr;
        sel_d   = gnt[1] ? m1_sel : m0_sel;
        wdata_d = gnt[1] ? m1_wdata : m0_wdata;
      end
    end else if (state_q == ARB_ACCESS) begin
      state_d = ARB_RESP;
      // Writes return ZeroWord; only the serviced requester's read port moves
      if (id_q == ID_M1) m1_rdata_d = we_q ? '0 : ram_rdata;
      else m0_rdata_d = we_q ? '0 : ram_rdata;
    end else begin
      state_d   = ARB_IDLE;
      rr_last_d = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      id_q       <= ID_M0;
      we_q       <= WRITE_DISABLE;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rr_last_q  <= ID_M1;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rr_last_q  <= rr_last_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    access     = state_q == ARB_ACCESS;
    resp       = state_q == ARB_RESP;
    ram_ce     = access ? CHIP_ENABLE : CHIP_DISABLE;
    ram_we     = access ? we_q : WRITE_DISABLE;
    ram_addr   = access ? addr_q : '0;
    ram_sel    = access ? sel_q : '0;
    ram_wdata  = access ? wdata_q : '0;
    m0_ack     = resp & (id_q == ID_M0);
    m1_ack     = resp & (id_q == ID_M1);
    m0_rdata   = m0_rdata_q;
    m1_rdata   = m1_rdata_q;
    stallreq_o = m0_req & ~m0_ack;
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: scoreboard bench driving a round-robin and a fixed-priority arbiter with identical stimulus.
module tb_data_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  always #5 clk = ~clk;

  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0] m0_sel = '0, m1_sel = '0;

  logic [31:0] r_m0_rdata, r_m1_rdata, r_ram_addr, r_ram_wdata, r_ram_rdata;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_ram_addr, f_ram_wdata, f_ram_rdata;
  logic r_m0_ack, r_m1_ack, r_ram_ce, r_ram_we, r_stall;
  logic f_m0_ack, f_m1_ack, f_ram_ce, f_ram_we, f_stall;
  logic [3:0] r_ram_sel, f_ram_sel;

  data_ram_arbiter #(.DW(32), .AW(32), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_rdata(r_m0_rdata), .m0_ack(r_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_rdata(r_m1_rdata), .m1_ack(r_m1_ack),
    .ram_ce(r_ram_ce), .ram_we(r_ram_we), .ram_addr(r_ram_addr), .ram_sel(r_ram_sel),
    .ram_wdata(r_ram_wdata), .ram_rdata(r_ram_rdata), .stallreq_o(r_stall)
  );

  data_ram_arbiter #(.DW(32), .AW(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_rdata(f_m0_rdata), .m0_ack(f_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_rdata(f_m1_rdata), .m1_ack(f_m1_ack),
    .ram_ce(f_ram_ce), .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_sel(f_ram_sel),
    .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata), .stallreq_o(f_stall)
  );

  logic [31:0] mem_r [64];
  logic [31:0] mem_f [64];
  assign r_ram_rdata = mem_r[r_ram_addr[7:2]];
  assign f_ram_rdata = mem_f[f_ram_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= 32'h55AA0000 + i;
        mem_f[i] <= 32'h55AA0000 + i;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_ram_ce && r_ram_we && r_ram_sel[b]) mem_r[r_ram_addr[7:2]][8*b +: 8] <= r_ram_wdata[8*b +: 8];
        if (f_ram_ce && f_ram_we && f_ram_sel[b]) mem_f[f_ram_addr[7:2]][8*b +: 8] <= f_ram_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {logic id; logic [31:0] data;} exp_t;
  exp_t q_r[$];
  exp_t q_f[$];
  exp_t er, ef;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] d);
    q_r.push_back({id, d});
    q_f.push_back({id, d});
  endtask

  always @(negedge clk) begin
    if (rst && (r_m0_ack || r_m1_ack)) begin
      if (q_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_ack got m0=%b m1=%b want none", r_m0_ack, r_m1_ack);
      end else begin
        er = q_r.pop_front();
        chk("rr_ack_id", {30'b0, r_m1_ack, r_m0_ack}, er.id ? 32'd2 : 32'd1);
        chk("rr_rdata", er.id ? r_m1_rdata : r_m0_rdata, er.data);
      end
    end
    if (rst && (f_m0_ack || f_m1_ack)) begin
      if (q_f.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fp_unexpected_ack got m0=%b m1=%b want none", f_m0_ack, f_m1_ack);
      end else begin
        ef = q_f.pop_front();
        chk("fp_ack_id", {30'b0, f_m1_ack, f_m0_ack}, ef.id ? 32'd2 : 32'd1);
        chk("fp_rdata", ef.id ? f_m1_rdata : f_m0_rdata, ef.data);
      end
    end
  end

  task automatic drive(input logic id, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata);
    if (id) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
    end
  endtask

  task automatic access(input logic id, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata);
    bit done = 1'b0;
    @(posedge clk);
    #1 drive(id, 1'b1, we, addr, sel, wdata);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = id ? r_m1_ack : r_m0_ack;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_m%0d got no ack want ack within 20 cycles", id);
    end
    @(posedge clk);
    #1 drive(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_ce", r_ram_ce, 0);
    chk("rst_ram_we", r_ram_we, 0);
    chk("rst_ram_addr", r_ram_addr, 0);
    chk("rst_m0_rdata", r_m0_rdata, 0);
    chk("rst_m1_rdata", f_m1_rdata, 0);
    chk("rst_acks", {r_m0_ack, r_m1_ack, f_m0_ack, f_m1_ack}, 0);
    preload = 1'b0;
    @(negedge clk) rst = 1'b1;
    // single-requester write then read back
    push(1'b0, 32'h0);
    access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    push(1'b0, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    // partial byte write on M1
    push(1'b1, 32'h0);
    access(1'b1, 1'b1, 32'h20, 4'b0100, 32'h11223344);
    push(1'b1, 32'h55220008);
    access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    // same-address race: M0 wins the tie and sees the old word
    push(1'b0, 32'h55AA0010);
    push(1'b1, 32'h0);
    fork
      access(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
      access(1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    join
    // both held for 12 cycles: RR alternates, fixed priority starves M1
    q_r.push_back({1'b0, 32'hDEADBEEF});
    q_r.push_back({1'b1, 32'h55220008});
    q_r.push_back({1'b0, 32'hDEADBEEF});
    q_r.push_back({1'b1, 32'h55220008});
    q_r.push_back({1'b1, 32'h55220008});
    for (int i = 0; i < 4; i++) q_f.push_back({1'b0, 32'hDEADBEEF});
    q_f.push_back({1'b1, 32'h55220008});
    fork
      begin
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        repeat (12) @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      begin
        bit seen = 1'b0;
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          seen = f_m1_ack;
        end
        chk("fp_m1_served_after_m0_drop", {31'b0, seen}, 1);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
    join
    // stall request timing
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("stall_n", {30'b0, r_stall, r_m0_ack}, 32'd2);
    @(negedge clk);
    chk("stall_n1", {30'b0, r_stall, r_m0_ack}, 32'd2);
    @(negedge clk);
    chk("stall_n2", {30'b0, r_stall, r_m0_ack}, 32'd1);
    chk("fp_stall_n2", {30'b0, f_stall, f_m0_ack}, 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    // reset during the ACCESS cycle of an M1 write
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h0BADF00D);
    @(posedge clk);
    #1 chk("pre_rst_ram_ce", r_ram_ce, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_ram_ce", {30'b0, r_ram_ce, f_ram_ce}, 0);
    chk("rst_mid_ack", {30'b0, r_m1_ack, f_m1_ack}, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    push(1'b0, 32'h55AA000C);
    access(1'b0, 1'b0, 32'h30, 4'hF, 32'h0);
    // M1's earlier write to 0x40 is now visible
    push(1'b0, 32'hCAFEF00D);
    access(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
    // sel=0 write still acks but changes no bytes
    push(1'b0, 32'h0);
    access(1'b0, 1'b1, 32'h10, 4'h0, 32'h12345678);
    push(1'b0, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    chk("rr_queue_empty", q_r.size(), 0);
    chk("fp_queue_empty", q_f.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
